cci_csr_regfile: RTL and testbench

- Parametrised MMIO CSR register file for an AFU.
- Decodes CCI-P c0 MMIO read/write requests (flattened header fields) into N 64-bit registers.
- Supports 4B and 8B accesses, read-only masks and hardware-side updates.
- Returns read responses through a buffered, back-pressurable c2 response port, so a shared c2 arbiter can sit downstream.

---
 rtl/cci_csr_regfile.sv | 192 +++++++++++++++++++
 tb/tb_cci_csr_regfile.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cci_csr_regfile.sv
`default_nettype none
// ============================================================================
// Module   : cci_csr_regfile
// Brief    : CCI-P MMIO CSR register file with 4B/8B access, read-only mask,
//            hardware update path and a buffered c2 read-response port.
// Revision : 1.0
// ============================================================================
module cci_csr_regfile #(
    parameter int                   N_CSRS          = 8,
    parameter logic [15:0]          CSR_BASE        = 16'h0020,
    parameter int                   RD_FIFO_DEPTH   = 4,
    parameter logic [N_CSRS-1:0]    RO_MASK         = '0,
    parameter logic [N_CSRS*64-1:0] RESET_VAL       = '0,
    parameter logic [63:0]          DEFAULT_RD_DATA = 64'h0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mmio_wr_valid,
    input  logic                   mmio_rd_valid,
    input  logic [15:0]            mmio_addr,
    input  logic [1:0]             mmio_len,
    input  logic [8:0]             mmio_tid,
    input  logic [63:0]            mmio_wdata,
    input  logic [N_CSRS-1:0]      hw_wr_en,
    input  logic [N_CSRS*64-1:0]   hw_wr_data,
    output logic [N_CSRS*64-1:0]   csr_q,
    output logic [N_CSRS-1:0]      csr_wr_pulse,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [8:0]             rsp_tid,
    output logic [63:0]            rsp_data,
    output logic [2:0]             err_status
);

    localparam int c_idx_w = (N_CSRS > 1) ? $clog2(N_CSRS) : 1;
    localparam int c_ptr_w = $clog2(RD_FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [15:0]        w_off;
    logic [c_idx_w-1:0] w_idx;
    logic               w_half;
    logic               w_hit;
    logic               w_len8;
    logic               w_len_bad;
    logic               w_misalign;
    logic               w_access_ok;
    logic [63:0]        w_sel;
    logic [63:0]        w_rd_data;

    assign w_off       = mmio_addr - CSR_BASE;
    assign w_idx       = w_off[c_idx_w:1];
    assign w_half      = w_off[0];
    assign w_hit       = (mmio_addr >= CSR_BASE) && ({1'b0, w_off[15:1]} < 16'(N_CSRS));
    assign w_len8      = (mmio_len == 2'd1);
    assign w_len_bad   = mmio_len[1];
    assign w_misalign  = w_len8 && w_half;
    assign w_access_ok = !w_len_bad && !w_misalign;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_CSRS; i++) begin
            if (w_idx == c_idx_w'(i)) begin
                w_sel = csr_q[i*64 +: 64];
            end
        end
    end

    // Read data is taken from the pre-edge register image, so a same-cycle write is not visible
    always_comb begin
        w_rd_data = DEFAULT_RD_DATA;
        if (w_hit && w_access_ok) begin
            if (w_len8) begin
                w_rd_data = w_sel;
            end else begin
                w_rd_data = {32'h0, (w_half ? w_sel[63:32] : w_sel[31:0])};
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CSRS; gi++) begin : g_csr
            logic        w_host_wr;
            logic [63:0] w_base;
            logic [63:0] w_next;
            logic [63:0] r_csr;
            logic        r_pulse;

            assign w_host_wr = mmio_wr_valid && w_hit && w_access_ok &&
                               (w_idx == c_idx_w'(gi)) && !RO_MASK[gi];
            // Hardware data forms the base so a 4B host write keeps the hw value in the other half
            assign w_base    = hw_wr_en[gi] ? hw_wr_data[gi*64 +: 64] : r_csr;

            always_comb begin
                w_next = w_base;
                if (w_host_wr) begin
                    if (w_len8) begin
                        w_next = mmio_wdata;
                    end else if (w_half) begin
                        w_next[63:32] = mmio_wdata[31:0];
                    end else begin
                        w_next[31:0] = mmio_wdata[31:0];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_csr   <= RESET_VAL[gi*64 +: 64];
                    r_pulse <= 1'b0;
                end else begin
                    r_csr   <= w_next;
                    r_pulse <= w_host_wr;
                end
            end

            assign csr_q[gi*64 +: 64] = r_csr;
            assign csr_wr_pulse[gi]   = r_pulse;
        end
    endgenerate

    logic               r_stg_valid;
    logic [8:0]         r_stg_tid;
    logic [63:0]        r_stg_data;
    logic [8:0]         r_fifo_tid  [RD_FIFO_DEPTH];
    logic [63:0]        r_fifo_data [RD_FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [2:0]         r_err;
    logic               w_req;
    logic               w_full;
    logic               w_pop;
    logic               w_push_ok;

    assign w_req     = mmio_wr_valid || mmio_rd_valid;
    assign w_full    = (r_count == c_cnt_w'(RD_FIFO_DEPTH));
    assign rsp_valid = (r_count != '0);
    assign w_pop     = rsp_valid && rsp_ready;
    assign w_push_ok = r_stg_valid && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stg_valid <= 1'b0;
            r_stg_tid   <= '0;
            r_stg_data  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_err       <= '0;
        end else begin
            r_stg_valid <= mmio_rd_valid;
            if (mmio_rd_valid) begin
                r_stg_tid  <= mmio_tid;
                r_stg_data <= w_rd_data;
            end
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (r_stg_valid && w_full && !w_pop) begin
                r_err[0] <= 1'b1;
            end
            if (w_req && w_hit && w_misalign) begin
                r_err[1] <= 1'b1;
            end
            if (w_req && w_hit && w_len_bad) begin
                r_err[2] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo_tid[r_wr_ptr]  <= r_stg_tid;
            r_fifo_data[r_wr_ptr] <= r_stg_data;
        end
    end

    assign rsp_tid    = rsp_valid ? r_fifo_tid[r_rd_ptr]  : '0;
    assign rsp_data   = rsp_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign err_status = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cci_csr_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_cci_csr_regfile
// Brief    : Self-checking bench for cci_csr_regfile with a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_cci_csr_regfile;

    localparam int           P_N     = 8;
    localparam logic [15:0]  P_BASE  = 16'h0020;
    localparam int           P_DEPTH = 4;
    localparam logic [7:0]   P_RO    = 8'h04;
    localparam logic [511:0] P_RST   = (512'h00A5 << 64) | (512'hCAFE << 320);
    localparam logic [63:0]  P_DEF   = 64'hBAD0_BAD0_BAD0_BAD0;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           mmio_wr_valid = 1'b0;
    logic           mmio_rd_valid = 1'b0;
    logic [15:0]    mmio_addr = '0;
    logic [1:0]     mmio_len = '0;
    logic [8:0]     mmio_tid = '0;
    logic [63:0]    mmio_wdata = '0;
    logic [7:0]     hw_wr_en = '0;
    logic [511:0]   hw_wr_data = '0;
    logic [511:0]   csr_q;
    logic [7:0]     csr_wr_pulse;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [8:0]     rsp_tid;
    logic [63:0]    rsp_data;
    logic [2:0]     err_status;

    cci_csr_regfile #(
        .N_CSRS          (P_N),
        .CSR_BASE        (P_BASE),
        .RD_FIFO_DEPTH   (P_DEPTH),
        .RO_MASK         (P_RO),
        .RESET_VAL       (P_RST),
        .DEFAULT_RD_DATA (P_DEF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mmio_wr_valid (mmio_wr_valid),
        .mmio_rd_valid (mmio_rd_valid),
        .mmio_addr     (mmio_addr),
        .mmio_len      (mmio_len),
        .mmio_tid      (mmio_tid),
        .mmio_wdata    (mmio_wdata),
        .hw_wr_en      (hw_wr_en),
        .hw_wr_data    (hw_wr_data),
        .csr_q         (csr_q),
        .csr_wr_pulse  (csr_wr_pulse),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_tid       (rsp_tid),
        .rsp_data      (rsp_data),
        .err_status    (err_status)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: register image, sticky errors, pulse vector, expected responses {tid,data}
    logic [63:0] m_reg [P_N];
    logic [2:0]  m_err;
    logic [7:0]  m_pulse;
    logic [72:0] sb [$];

    function automatic logic [511:0] model_flat();
        logic [511:0] v;
        for (int i = 0; i < P_N; i++) v[i*64 +: 64] = m_reg[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < P_N; i++) m_reg[i] = P_RST[i*64 +: 64];
        m_err   = '0;
        m_pulse = '0;
        sb.delete();
    endtask

    task automatic model_apply();
        int          off;
        int          idx;
        bit          hit;
        bit          half;
        bit          bad;
        bit          mis;
        logic [63:0] rdat;
        off  = int'(mmio_addr) - int'(P_BASE);
        hit  = (off >= 0) && ((off / 2) < P_N);
        idx  = hit ? off / 2 : 0;
        half = hit && ((off % 2) == 1);
        bad  = (mmio_len >= 2);
        mis  = (mmio_len == 1) && half;
        if (hit && !bad && !mis)
            rdat = (mmio_len == 1) ? m_reg[idx]
                 : {32'h0, (half ? m_reg[idx][63:32] : m_reg[idx][31:0])};
        else
            rdat = P_DEF;
        if (mmio_rd_valid) begin
            if (sb.size() >= P_DEPTH) m_err[0] = 1'b1;
            else sb.push_back({mmio_tid, rdat});
        end
        if ((mmio_rd_valid || mmio_wr_valid) && hit && mis) m_err[1] = 1'b1;
        if ((mmio_rd_valid || mmio_wr_valid) && hit && bad) m_err[2] = 1'b1;
        m_pulse = '0;
        for (int i = 0; i < P_N; i++)
            if (hw_wr_en[i]) m_reg[i] = hw_wr_data[i*64 +: 64];
        if (mmio_wr_valid && hit && !bad && !mis && !P_RO[idx]) begin
            if (mmio_len == 1)  m_reg[idx] = mmio_wdata;
            else if (half)      m_reg[idx][63:32] = mmio_wdata[31:0];
            else                m_reg[idx][31:0]  = mmio_wdata[31:0];
            m_pulse[idx] = 1'b1;
        end
    endtask

    task automatic tick();
        if (reset) model_reset();
        else model_apply();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mmio_wr_valid = 0; mmio_rd_valid = 0; hw_wr_en = '0;
    endtask

    task automatic issue(input bit wr, input bit rd, input logic [15:0] a,
                         input logic [1:0] len, input logic [8:0] tid, input logic [63:0] wd);
        mmio_wr_valid = wr; mmio_rd_valid = rd; mmio_addr = a;
        mmio_len = len; mmio_tid = tid; mmio_wdata = wd;
        tick();
        idle_inputs();
    endtask

    task automatic get_rsp(output bit ok, output logic [8:0] tid, output logic [63:0] data);
        ok = 0; tid = '0; data = '0;
        rsp_ready = 1;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid) begin
                tid = rsp_tid; data = rsp_data; ok = 1;
                if (sb.size() > 0) void'(sb.pop_front());
                tick();
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1;
        tick(); tick();
        reset = 0;
        tick();
        n_checks++; if (csr_q !== P_RST) begin n_errors++; $display("FAIL reset_csr_q got %h exp %h", csr_q, P_RST); end
        n_checks++; if (csr_q[127:64] !== 64'hA5) begin n_errors++; $display("FAIL reset_reg1 got %h exp a5", csr_q[127:64]); end
        n_checks++; if (csr_wr_pulse !== 8'h0) begin n_errors++; $display("FAIL reset_pulse got %h exp 0", csr_wr_pulse); end
        n_checks++; if ({rsp_valid, rsp_tid, rsp_data} !== 74'h0) begin n_errors++; $display("FAIL reset_rsp got v=%b t=%h d=%h exp 0", rsp_valid, rsp_tid, rsp_data); end
        n_checks++; if (err_status !== 3'b000) begin n_errors++; $display("FAIL reset_err got %b exp 000", err_status); end
    endtask

    task automatic test_basic();
        rsp_ready = 1;
        issue(1, 0, 16'h0022, 2'd1, 9'h0, 64'h1122334455667788);
        n_checks++; if (csr_q[127:64] !== 64'h1122334455667788) begin n_errors++; $display("FAIL wr8_reg1 got %h exp 1122334455667788", csr_q[127:64]); end
        n_checks++; if (csr_wr_pulse !== 8'h02) begin n_errors++; $display("FAIL wr8_pulse got %h exp 02", csr_wr_pulse); end
        tick();
        n_checks++; if (csr_wr_pulse !== 8'h00) begin n_errors++; $display("FAIL wr8_pulse_drop got %h exp 00", csr_wr_pulse); end
        issue(0, 1, 16'h0022, 2'd1, 9'h05, 64'h0);
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rd_lat_t1 got %b exp 0", rsp_valid); end
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_tid !== 9'h05 || rsp_data !== 64'h1122334455667788) begin
            n_errors++; $display("FAIL rd8_t2 got v=%b t=%h d=%h exp v=1 t=005 d=1122334455667788", rsp_valid, rsp_tid, rsp_data); end
        void'(sb.pop_front());
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rd8_popped got %b exp 0", rsp_valid); end
        issue(1, 0, 16'h0023, 2'd0, 9'h0, 64'h00000000DEADBEEF);
        n_checks++; if (csr_q[127:64] !== 64'hDEADBEEF55667788) begin n_errors++; $display("FAIL wr4_hi got %h exp deadbeef55667788", csr_q[127:64]); end
        begin
            bit ok; logic [8:0] t; logic [63:0] d;
            issue(0, 1, 16'h0023, 2'd0, 9'h06, 64'h0);
            get_rsp(ok, t, d);
            n_checks++; if (!ok || t !== 9'h06 || d !== 64'h00000000DEADBEEF) begin
                n_errors++; $display("FAIL rd4_hi got ok=%b t=%h d=%h exp t=006 d=00000000deadbeef", ok, t, d); end
        end
    endtask

    task automatic test_ro_hw();
        hw_wr_en = 8'h04; hw_wr_data[128 +: 64] = 64'h7;
        issue(1, 0, 16'h0024, 2'd1, 9'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        n_checks++; if (csr_q[128 +: 64] !== 64'h7) begin n_errors++; $display("FAIL ro_hw_reg2 got %h exp 7", csr_q[128 +: 64]); end
        n_checks++; if (csr_wr_pulse !== 8'h00) begin n_errors++; $display("FAIL ro_pulse got %h exp 00", csr_wr_pulse); end
        hw_wr_en = 8'h08; hw_wr_data[192 +: 64] = 64'h1111;
        issue(1, 0, 16'h0026, 2'd1, 9'h0, 64'hABCD_0000_1234_5678);
        n_checks++; if (csr_q[192 +: 64] !== 64'hABCD_0000_1234_5678 || csr_wr_pulse !== 8'h08) begin
            n_errors++; $display("FAIL host_wins_reg3 got %h p=%h exp abcd000012345678 p=08", csr_q[192 +: 64], csr_wr_pulse); end
        hw_wr_en = 8'h10; hw_wr_data[256 +: 64] = 64'h0123456789ABCDEF;
        issue(1, 0, 16'h0028, 2'd0, 9'h0, 64'h55AA55AA);
        n_checks++; if (csr_q[256 +: 64] !== 64'h0123456755AA55AA) begin n_errors++; $display("FAIL host4_hw_half got %h exp 0123456755aa55aa", csr_q[256 +: 64]); end
        n_checks++; if (csr_q !== model_flat()) begin n_errors++; $display("FAIL ro_hw_model got %h exp %h", csr_q, model_flat()); end
    endtask

    task automatic test_errors();
        bit ok; logic [8:0] t; logic [63:0] d;
        issue(0, 1, 16'h0021, 2'd1, 9'h07, 64'h0);
        get_rsp(ok, t, d);
        n_checks++; if (!ok || t !== 9'h07 || d !== P_DEF || err_status !== 3'b010) begin
            n_errors++; $display("FAIL misalign_rd got ok=%b t=%h d=%h e=%b exp t=007 d=%h e=010", ok, t, d, err_status, P_DEF); end
        issue(0, 1, 16'h0040, 2'd1, 9'h08, 64'h0);
        get_rsp(ok, t, d);
        n_checks++; if (!ok || t !== 9'h08 || d !== P_DEF || err_status !== 3'b010) begin
            n_errors++; $display("FAIL miss_rd got ok=%b t=%h d=%h e=%b exp t=008 d=%h e=010", ok, t, d, err_status, P_DEF); end
        issue(1, 0, 16'h0022, 2'd2, 9'h0, 64'h0);
        n_checks++; if (err_status !== 3'b110 || csr_q[127:64] !== 64'hDEADBEEF55667788 || csr_wr_pulse !== 8'h0) begin
            n_errors++; $display("FAIL badlen_wr got e=%b r=%h p=%h exp e=110 r=deadbeef55667788 p=00", err_status, csr_q[127:64], csr_wr_pulse); end
    endtask

    task automatic test_overflow();
        rsp_ready = 0;
        for (int i = 0; i < 5; i++) begin
            mmio_rd_valid = 1; mmio_addr = 16'h0022; mmio_len = 2'd1; mmio_tid = 9'(9'h11 + i);
            tick();
        end
        idle_inputs();
        tick(); tick();
        n_checks++; if (rsp_valid !== 1'b1 || rsp_tid !== 9'h11 || err_status[0] !== 1'b1) begin
            n_errors++; $display("FAIL ovf_hold got v=%b t=%h e=%b exp v=1 t=011 e0=1", rsp_valid, rsp_tid, err_status); end
        tick();
        n_checks++; if (rsp_tid !== 9'h11 || rsp_data !== 64'hDEADBEEF55667788) begin
            n_errors++; $display("FAIL ovf_stable got t=%h d=%h exp t=011 d=deadbeef55667788", rsp_tid, rsp_data); end
        for (int i = 0; i < 4; i++) begin
            bit ok; logic [8:0] t; logic [63:0] d;
            get_rsp(ok, t, d);
            n_checks++; if (!ok || t !== 9'(9'h11 + i)) begin n_errors++; $display("FAIL ovf_order%0d got ok=%b t=%h exp %h", i, ok, t, 9'(9'h11 + i)); end
        end
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL ovf_drained got %b exp 0", rsp_valid); end
    endtask

    task automatic test_reset_mid();
        bit ok; logic [8:0] t; logic [63:0] d;
        rsp_ready = 0;
        issue(0, 1, 16'h0022, 2'd1, 9'h31, 64'h0);
        issue(0, 1, 16'h0024, 2'd1, 9'h32, 64'h0);
        tick(); tick();
        n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL mid_queued got %b exp 1", rsp_valid); end
        reset = 1;
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || err_status !== 3'b000) begin
            n_errors++; $display("FAIL mid_reset got v=%b e=%b exp v=0 e=000", rsp_valid, err_status); end
        reset = 0;
        tick();
        issue(0, 1, 16'h0022, 2'd1, 9'h33, 64'h0);
        get_rsp(ok, t, d);
        n_checks++; if (!ok || t !== 9'h33 || d !== 64'hA5 || err_status !== 3'b000) begin
            n_errors++; $display("FAIL mid_after got ok=%b t=%h d=%h e=%b exp t=033 d=a5 e=000", ok, t, d, err_status); end
    endtask

    task automatic test_random();
        logic [72:0] exp_e;
        for (int c = 0; c < 400; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++; $display("FAIL rnd_rsp_unexpected got t=%h d=%h exp none", rsp_tid, rsp_data);
                end else begin
                    exp_e = sb.pop_front();
                    if ({rsp_tid, rsp_data} !== exp_e) begin
                        n_errors++; $display("FAIL rnd_rsp got t=%h d=%h exp t=%h d=%h", rsp_tid, rsp_data, exp_e[72:64], exp_e[63:0]);
                    end
                end
            end
            mmio_wr_valid = ($urandom_range(0, 2) == 0);
            mmio_rd_valid = (sb.size() < P_DEPTH) && ($urandom_range(0, 2) == 0);
            mmio_addr     = 16'($urandom_range(16'h001E, 16'h0031));
            mmio_len      = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            mmio_tid      = 9'($urandom);
            mmio_wdata    = {$urandom, $urandom};
            hw_wr_en      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
            for (int i = 0; i < 16; i++) hw_wr_data[i*32 +: 32] = $urandom;
            tick();
            n_checks++;
            if (csr_q !== model_flat() || csr_wr_pulse !== m_pulse || err_status !== m_err) begin
                n_errors++;
                $display("FAIL rnd_state cyc %0d got p=%h e=%b exp p=%h e=%b regs_match=%b", c, csr_wr_pulse, err_status, m_pulse, m_err, csr_q === model_flat());
            end
        end
        idle_inputs();
        rsp_ready = 1;
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            if (rsp_valid) begin
                exp_e = sb.pop_front();
                n_checks++;
                if ({rsp_tid, rsp_data} !== exp_e) begin
                    n_errors++; $display("FAIL rnd_drain got t=%h d=%h exp t=%h d=%h", rsp_tid, rsp_data, exp_e[72:64], exp_e[63:0]);
                end
            end
            tick();
        end
        n_checks++;
        if (sb.size() != 0 || rsp_valid !== 1'b0) begin
            n_errors++; $display("FAIL rnd_drain_timeout got pending=%0d v=%b exp 0", sb.size(), rsp_valid);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_ro_hw();
        test_errors();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
